// File: rtl/histo_accum_multilane.sv
// Multi-lane frame histogram: per-lane RAM banks with a forwarded RMW pipeline, then a
// lane-summed, clear-on-read valid/ready stream with a frame-ID header on bin 0.
module histo_accum_multilane #(
    parameter int NUM_LANES = 2,
    parameter int PIXEL_W   = 10,
    parameter int BIN_W     = 10,
    parameter int COUNT_W   = 24,
    parameter int FID_W     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES*PIXEL_W-1:0]   pixel_data,
    input  logic                           frame_valid,
    input  logic                           line_valid,
    input  logic [2:0]                     bin_shift,
    output logic [FID_W+COUNT_W-1:0]       out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           sat_flag,
    output logic [FID_W-1:0]               drop_count
);
    localparam int NUM_BINS = 1 << BIN_W;
    localparam int SUM_W    = COUNT_W + $clog2(NUM_LANES) + 1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_READOUT} state_t;
    state_t r_state, w_next;

    logic                         r_fv_d, w_fv_rise, w_fv_fall, w_pix_vld;
    logic [BIN_W-1:0]             r_clr_addr;
    logic [1:0]                   r_drain_cnt;
    logic [2:0]                   r_shift;
    logic [FID_W-1:0]             r_fid, r_hdr_fid, r_drop;
    logic                         r_sat;
    logic [BIN_W:0]               r_rd_addr;
    logic                         r_ra_vld, r_out_vld, r_out_last;
    logic [BIN_W-1:0]             r_ra_addr, r_out_addr;
    logic [FID_W+COUNT_W-1:0]     r_out_data;
    logic                         w_accept, w_load, w_issue, w_re, w_clr_we;
    logic [NUM_LANES-1:0]         w_sat_hit;
    logic [NUM_LANES*COUNT_W-1:0] w_rd_flat;
    logic [SUM_W-1:0]             w_sum;
    logic [COUNT_W-1:0]           w_sum_sat;
    logic [FID_W-1:0]             w_hdr;

    assign w_fv_rise = frame_valid & ~r_fv_d;
    assign w_fv_fall = ~frame_valid & r_fv_d;
    assign w_pix_vld = frame_valid & line_valid & (r_state == S_ACCUM);

    // Read register doubles as the skid slot: it only reloads when its word moves on.
    assign w_accept = r_out_vld & out_ready;
    assign w_load   = r_ra_vld & (~r_out_vld | out_ready);
    assign w_issue  = (r_state == S_READOUT) & ~r_rd_addr[BIN_W] & (~r_ra_vld | w_load);
    assign w_re     = w_issue | w_pix_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_CLEAR;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR:   if (&r_clr_addr) w_next = S_IDLE;
            S_IDLE:    if (w_fv_rise) w_next = S_ACCUM;
            S_ACCUM:   if (w_fv_fall) w_next = S_DRAIN;
            S_DRAIN:   if (r_drain_cnt == 2'd0) w_next = S_READOUT;
            S_READOUT: if (w_accept && r_out_last) w_next = S_IDLE;
            default:   w_next = S_CLEAR;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        w_clr_we = (r_state == S_CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fv_d      <= 1'b0;
            r_clr_addr  <= '0;
            r_drain_cnt <= '0;
            r_shift     <= '0;
            r_fid       <= '0;
            r_hdr_fid   <= '0;
            r_drop      <= '0;
            r_sat       <= 1'b0;
            r_rd_addr   <= '0;
            r_ra_vld    <= 1'b0;
            r_ra_addr   <= '0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_fv_d <= frame_valid;
            if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
            if (r_state == S_IDLE && w_fv_rise) begin
                r_shift <= bin_shift;
                r_sat   <= 1'b0;
            end else if (|w_sat_hit) begin
                r_sat <= 1'b1;
            end
            if (r_state == S_ACCUM && w_fv_fall) begin
                r_hdr_fid   <= r_fid;
                r_fid       <= r_fid + 1'b1;
                r_drain_cnt <= 2'd2;
                r_rd_addr   <= '0;
            end
            if (r_state == S_DRAIN && r_drain_cnt != 2'd0) r_drain_cnt <= r_drain_cnt - 1'b1;
            if (w_fv_rise && (r_state == S_CLEAR || r_state == S_DRAIN || r_state == S_READOUT))
                r_drop <= r_drop + 1'b1;
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_ra_addr <= r_rd_addr[BIN_W-1:0];
                r_ra_vld  <= 1'b1;
            end else if (w_load) begin
                r_ra_vld <= 1'b0;
            end
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_data <= {w_hdr, w_sum_sat};
                r_out_last <= &r_ra_addr;
                r_out_addr <= r_ra_addr;
            end else if (w_accept) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end

    assign w_hdr = (r_ra_addr == '0) ? r_hdr_fid : '0;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_LANES; k++)
            w_sum = w_sum + SUM_W'(w_rd_flat[k*COUNT_W +: COUNT_W]);
    end
    assign w_sum_sat = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[COUNT_W-1:0];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [COUNT_W-1:0] r_bank [NUM_BINS];
        logic [COUNT_W-1:0] r_rd_data, w_base, w_inc, w_wdata, r_s2_cnt, r_s3_cnt;
        logic [PIXEL_W-1:0] w_pix_sh;
        logic [BIN_W-1:0]   w_bin, w_raddr, w_waddr, r_s1_addr, r_s2_addr, r_s3_addr;
        logic               r_s1_vld, r_s2_vld, r_s3_vld, w_we;

        assign w_pix_sh = pixel_data[k*PIXEL_W +: PIXEL_W] >> r_shift;
        assign w_bin    = w_pix_sh[BIN_W-1:0];
        assign w_raddr  = (r_state == S_READOUT) ? r_rd_addr[BIN_W-1:0] : w_bin;

        // s2 is not yet written; s3 was written on the same edge the s1 read sampled old data.
        always_comb begin
            w_base = r_rd_data;
            if (r_s2_vld && r_s2_addr == r_s1_addr)      w_base = r_s2_cnt;
            else if (r_s3_vld && r_s3_addr == r_s1_addr) w_base = r_s3_cnt;
        end
        assign w_inc        = (w_base == CNT_MAX) ? CNT_MAX : w_base + 1'b1;
        assign w_sat_hit[k] = r_s1_vld & (w_base == CNT_MAX);

        always_comb begin
            w_we    = 1'b0;
            w_waddr = r_s2_addr;
            w_wdata = r_s2_cnt;
            if (w_clr_we) begin
                w_we = 1'b1; w_waddr = r_clr_addr; w_wdata = '0;
            end else if (r_s2_vld) begin
                w_we = 1'b1;
            end else if (w_accept) begin
                w_we = 1'b1; w_waddr = r_out_addr; w_wdata = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (w_we) r_bank[w_waddr] <= w_wdata;
            if (w_re) r_rd_data <= r_bank[w_raddr];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s1_vld <= 1'b0; r_s1_addr <= '0;
                r_s2_vld <= 1'b0; r_s2_addr <= '0; r_s2_cnt <= '0;
                r_s3_vld <= 1'b0; r_s3_addr <= '0; r_s3_cnt <= '0;
            end else begin
                r_s1_vld <= w_pix_vld; r_s1_addr <= w_bin;
                r_s2_vld <= r_s1_vld;  r_s2_addr <= r_s1_addr; r_s2_cnt <= w_inc;
                r_s3_vld <= r_s2_vld;  r_s3_addr <= r_s2_addr; r_s3_cnt <= r_s2_cnt;
            end
        end

        assign w_rd_flat[k*COUNT_W +: COUNT_W] = r_rd_data;
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_vld;
    assign out_last   = r_out_last;
    assign sat_flag   = r_sat;
    assign drop_count = r_drop;
endmodule

// File: tb/tb_histo_accum_multilane.sv
// Directed bench: default build plus a 4-bit-count build driven in lockstep for saturation.
module tb_histo_accum_multilane;
    localparam int NB = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] pixel_data;
    logic        frame_valid, line_valid, out_ready;
    logic [2:0]  bin_shift;
    logic [31:0] od;
    logic        ov, ol, busy, sat;
    logic [7:0]  drop;
    logic [11:0] s_od;
    logic        s_ov, s_ol, s_busy, s_sat;
    logic [7:0]  s_drop;

    int checks = 0;
    int errors = 0;
    int exp_h [NB];
    int sh;
    logic [31:0] words [NB];
    logic [11:0] swords [NB];
    int nwords, lastbad, stallbad;

    histo_accum_multilane u_dut (
        .clk(clk), .reset(reset), .pixel_data(pixel_data), .frame_valid(frame_valid),
        .line_valid(line_valid), .bin_shift(bin_shift), .out_data(od), .out_valid(ov),
        .out_ready(out_ready), .out_last(ol), .busy(busy), .sat_flag(sat), .drop_count(drop)
    );

    histo_accum_multilane #(.COUNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .pixel_data(pixel_data), .frame_valid(frame_valid),
        .line_valid(line_valid), .bin_shift(bin_shift), .out_data(s_od), .out_valid(s_ov),
        .out_ready(out_ready), .out_last(s_ol), .busy(s_busy), .sat_flag(s_sat), .drop_count(s_drop)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NB; i++) exp_h[i] = 0;
    endtask

    task automatic start_frame(input int shift);
        sh          = shift;
        bin_shift   = 3'(shift);
        frame_valid = 1'b1;
        line_valid  = 1'b0;
        tick(2);
    endtask

    task automatic feed(input int p0, input int p1);
        pixel_data = {10'(p1), 10'(p0)};
        line_valid = 1'b1;
        exp_h[(p0 >> sh) & (NB-1)]++;
        exp_h[(p1 >> sh) & (NB-1)]++;
        tick(1);
    endtask

    task automatic end_frame();
        line_valid = 1'b0;
        tick(1);
        frame_valid = 1'b0;
        tick(1);
    endtask

    task automatic readout(input bit rnd, input bit inject_drop, input int stop_at);
        logic [31:0] prev;
        bit stalled;
        nwords = 0; lastbad = 0; stallbad = 0; stalled = 0; prev = '0;
        for (int c = 0; c < 6000 && nwords < NB; c++) begin
            if (inject_drop && nwords == 100) begin
                frame_valid = 1'b1; line_valid = 1'b1; pixel_data = {10'd300, 10'd300};
            end
            if (inject_drop && nwords == 200) begin
                frame_valid = 1'b0; line_valid = 1'b0;
            end
            if (stop_at >= 0 && nwords == stop_at) break;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (ov !== 1'b1 || od !== prev)) stallbad++;
            if (ov && out_ready) begin
                words[nwords]  = od;
                swords[nwords] = s_od;
                if (ol !== (nwords == NB-1) || s_ol !== (nwords == NB-1)) lastbad++;
                nwords++;
            end
            stalled = ov && !out_ready;
            prev    = od;
            tick(1);
        end
        out_ready = 1'b1;
    endtask

    task automatic compare(input string tag, input int fid);
        int bad;
        logic [31:0] expv;
        bad = 0;
        for (int i = 0; i < NB; i++) begin
            expv = {(i == 0) ? 8'(fid) : 8'h00, 24'(exp_h[i])};
            if (words[i] !== expv) bad++;
        end
        chk({tag, "_words"}, nwords, NB);
        chk({tag, "_bins"}, bad, 0);
        chk({tag, "_last"}, lastbad, 0);
    endtask

    initial begin
        reset = 1'b0; pixel_data = '0; frame_valid = 1'b0; line_valid = 1'b0;
        bin_shift = 3'd0; out_ready = 1'b1; sh = 0;
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_valid", ov, 0);
        chk("rst_data", od, 0);
        chk("rst_last", ol, 0);
        chk("rst_sat", sat, 0);
        chk("rst_drop", drop, 0);
        chk("rst_s_busy", s_busy, 1);
        tick(2);
        reset = 1'b1;
        tick(NB + 2);
        chk("clear_done_busy", busy, 0);

        // empty frame
        clear_model();
        start_frame(0);
        tick(8);
        end_frame();
        readout(0, 0, -1);
        compare("empty", 0);
        chk("empty_hdr0", words[0][31:24], 8'h00);
        tick(1);
        chk("empty_busy_after", busy, 0);

        // same-bin collisions, both lanes, every cycle
        clear_model();
        start_frame(0);
        for (int i = 0; i < 100; i++) feed(5, 5);
        end_frame();
        readout(0, 0, -1);
        compare("collide", 1);
        chk("collide_bin5", words[5][23:0], 200);
        chk("collide_hdr", words[0][31:24], 8'h01);

        // same frame under random backpressure
        clear_model();
        start_frame(0);
        for (int i = 0; i < 100; i++) feed(5, 5);
        end_frame();
        readout(1, 0, -1);
        compare("bp", 2);
        chk("bp_stall_stable", stallbad, 0);

        // bin_shift = 2 ramp
        clear_model();
        start_frame(2);
        for (int i = 0; i < NB; i++) feed(i, 1023);
        end_frame();
        readout(0, 0, -1);
        compare("shift", 3);
        chk("shift_bin0", words[0][23:0], 4);
        chk("shift_bin255", words[255][23:0], 1028);
        chk("shift_bin256", words[256][23:0], 0);

        // saturation in the 4-bit build; sticky flag from earlier frames clears at frame start
        chk("sat_sticky_before", s_sat, 1);
        clear_model();
        start_frame(0);
        chk("sat_cleared_at_start", s_sat, 0);
        for (int i = 0; i < 20; i++) feed(7, 0);
        end_frame();
        chk("sat_set", s_sat, 1);
        chk("sat_wide_clear", sat, 0);
        readout(0, 0, -1);
        compare("sat_wide", 4);
        chk("sat_bin7", swords[7][3:0], 4'hF);
        chk("sat_bin0", swords[0], {8'h04, 4'hF});

        // frame arriving during readout is dropped
        clear_model();
        start_frame(0);
        for (int i = 0; i < 10; i++) feed(100, 200);
        end_frame();
        readout(0, 1, -1);
        compare("drop_frame", 5);
        chk("drop_count", drop, 1);
        chk("drop_count_s", s_drop, 1);
        clear_model();
        start_frame(0);
        for (int i = 0; i < 5; i++) feed(50, 60);
        end_frame();
        readout(0, 0, -1);
        compare("after_drop", 6);

        // reset in the middle of readout
        clear_model();
        start_frame(0);
        for (int i = 0; i < 8; i++) feed(400, 400);
        end_frame();
        readout(0, 0, 300);
        chk("mid_words", nwords, 300);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", ov, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_drop", drop, 0);
        tick(3);
        reset = 1'b1;
        tick(NB + 2);
        chk("mid_clear_busy", busy, 0);
        clear_model();
        start_frame(0);
        for (int i = 0; i < 3; i++) feed(9, 10);
        end_frame();
        readout(0, 0, -1);
        compare("post_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/histo_accum_multilane.md
Name: histo_accum_multilane

Overview:
Parametrised successor to the two-lane camera histogram block. It accumulates per-frame pixel-intensity histograms from NUM_LANES pixels per clock into per-lane RAM banks. Bins are selected with a programmable right-shift. After frame end it streams the lane-summed histogram over a valid/ready interface with a frame-ID header, clearing each bin as it is read. It sits between the sensor pixel bus and the SPI/packetiser stage, replacing the fixed two-lane accumulator plus serializer coupling.

Parameters:
NUM_LANES, 2, pixels presented per clock.
PIXEL_W, 10, bits per pixel.
BIN_W, 10, log2(number of bins); NUM_BINS = 2^BIN_W; BIN_W <= PIXEL_W.
COUNT_W, 24, per-bin count width, saturating.
FID_W, 8, frame-ID width.

Ports:
clk  in  1  pixel/system clock.
reset  in  1  asynchronous, active-low reset.
pixel_data  in  NUM_LANES*PIXEL_W  lane k at bits [k*PIXEL_W +: PIXEL_W].
frame_valid  in  1  frame window.
line_valid  in  1  line window; pixel valid = frame_valid & line_valid.
bin_shift  in  3  right-shift applied to the pixel before binning; bin = (pix >> bin_shift) truncated to BIN_W.
out_data  out  FID_W+COUNT_W  {header_or_zero, count}.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready.
out_last  out  1  marks bin NUM_BINS-1.
busy  out  1  high in any state other than IDLE.
sat_flag  out  1  sticky; a bin saturated in the current or last frame.
drop_count  out  FID_W  frames ignored because they arrived during READOUT/CLEAR; wraps.

Behaviour:
- Reset values (on assertion of reset, async): state=CLEAR, out_valid=0, out_last=0, out_data=0, sat_flag=0, drop_count=0, frame_id=0, busy=1.
- States: CLEAR -> IDLE -> ACCUM -> DRAIN -> READOUT -> IDLE.
- CLEAR: writes 0 to every address of every bank, one address per cycle (NUM_BINS cycles), then goes to IDLE. Entered only from reset.
- IDLE: rising edge of frame_valid (registered compare) -> ACCUM. sat_flag is cleared on this transition.
- ACCUM, per lane, 3-stage read-modify-write pipeline: address/read, increment, write.
  - Back-to-back hits to the same bin in the same lane are forwarded from the in-flight stage, so no increment is lost. Required: N consecutive identical pixels yield exactly N.
  - Lanes own separate banks, so no cross-lane conflict exists.
  - Count saturates at 2^COUNT_W-1 and sets sat_flag.
  - Falling edge of frame_valid -> DRAIN.
- DRAIN: 3 cycles to retire the pipeline, then READOUT. frame_id is latched for the header, and the internal frame_id counter increments (wrap).
- READOUT, per word:
  - Bin address 0..NUM_BINS-1 in order. out_data count = saturating sum across lanes of bank[addr].
  - Upper FID_W bits = frame_id for bin 0, zero otherwise.
  - Banks are read with 1-cycle latency. A prefetch/skid register keeps one word per cycle when out_ready is held high.
  - out_valid/out_data/out_last hold stable while out_valid & !out_ready.
  - On each accepted word (out_valid & out_ready), that bin is written 0 in all banks (clear-on-read).
  - After bin NUM_BINS-1 is accepted -> IDLE. out_last=1 only with that word.
- A frame_valid rising edge seen in DRAIN, READOUT or CLEAR increments drop_count. That frame is ignored entirely; ACCUM is not entered until the next rising edge seen in IDLE.
- frame_valid already high when entering IDLE: no entry; a fresh rising edge is required.
- Pixel valid outside ACCUM: ignored.
- Reset mid-ACCUM or mid-READOUT: immediate return to CLEAR; the partial frame and stream are discarded; out_valid drops asynchronously.
- bin_shift is sampled on the IDLE->ACCUM transition and held for the frame.

Test Plan:
- Reset and CLEAR: release reset, wait NUM_BINS+2 cycles with no frame, then run one empty frame (frame_valid 10 cycles, line_valid 0) -> 1024 words, all count 0; word0 header 0x00; out_last only on word 1023; busy low after.
- Collision forwarding: one line, 100 cycles, lane0=5 and lane1=5 every cycle, out_ready=1 -> bin5 count 200, all others 0, header of next frame = 0x01.
- Backpressure: same frame, out_ready toggled 1/0 pseudo-randomly -> identical 1024-word sequence; out_data stable while stalled; no word skipped or duplicated.
- Shift/mode: bin_shift=2, pixels 0..1023 ramp on lane0, lane1 held at 1023 -> bins 0..255 each = 4, bin 255 = 4+N_pixels; bins 256..1023 = 0.
- Saturation: COUNT_W=4 build, 20 pixels of value 7 on lane0 -> bin7 count 15, sat_flag=1; sat_flag clears on next frame start.
- Drop and reset: assert frame_valid during READOUT -> drop_count=1, that frame's pixels absent from the following histogram. Assert reset at word 300 -> out_valid low immediately; after CLEAR, the next frame reads all-zero except its own pixels.
